i_raster_counter: RTL and testbench



---
 rtl/i_raster_counter.sv | 154 +++++++++++++++
 tb/tb_i_raster_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_raster_counter.sv
// Raster-scan pixel index generator: walks a width x height frame in row-major order
// with a runtime stride and emits column, row and linear address under valid/ready.
module i_raster_counter #(
    parameter int COL_BITS    = 13,
    parameter int ROW_BITS    = 13,
    parameter int STRIDE_BITS = 4,
    parameter int ADDR_BITS   = COL_BITS + ROW_BITS
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   start,
    input  logic [COL_BITS-1:0]    img_width,
    input  logic [ROW_BITS-1:0]    img_height,
    input  logic [STRIDE_BITS-1:0] stride,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [COL_BITS-1:0]    col,
    output logic [ROW_BITS-1:0]    row,
    output logic [ADDR_BITS-1:0]   addr,
    output logic                   line_end,
    output logic                   frame_end,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_error
);

    localparam int CW1 = COL_BITS + 1;
    localparam int RW1 = ROW_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COL_BITS-1:0]    col_q, col_d, width_q, width_d;
    logic [ROW_BITS-1:0]    row_q, row_d, height_q, height_d;
    logic [STRIDE_BITS-1:0] stride_q, stride_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d, row_base_q, row_base_d, row_step_q, row_step_d;
    logic                   out_valid_q, out_valid_d, busy_q, busy_d;
    logic                   done_q, done_d, cfg_error_q, cfg_error_d;

    logic [CW1-1:0]       col_sum;
    logic [RW1-1:0]       row_sum;
    logic                 last_col, last_row, handshake, cfg_ok;
    logic [ADDR_BITS-1:0] step_calc;

    // Sums carry one extra bit so the end-of-line test never sees a wrapped column.
    assign col_sum   = {1'b0, col_q} + CW1'(stride_q);
    assign row_sum   = {1'b0, row_q} + RW1'(stride_q);
    assign last_col  = (col_sum >= {1'b0, width_q});
    assign last_row  = (row_sum >= {1'b0, height_q});
    assign handshake = out_valid_q & out_ready;
    assign cfg_ok    = (img_width != '0) && (img_height != '0) && (stride != '0);
    assign step_calc = ADDR_BITS'(img_width) * ADDR_BITS'(stride);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        row_base_d  = row_base_q;
        row_step_d  = row_step_q;
        width_d     = width_q;
        height_d    = height_q;
        stride_d    = stride_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d     = img_width;
                        height_d    = img_height;
                        stride_d    = stride;
                        row_step_d  = step_calc;
                        col_d       = '0;
                        row_d       = '0;
                        addr_d      = '0;
                        row_base_d  = '0;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (handshake) begin
                    if (last_col && last_row) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else if (last_col) begin
                        col_d      = '0;
                        row_d      = row_sum[ROW_BITS-1:0];
                        row_base_d = row_base_q + row_step_q;
                        addr_d     = row_base_q + row_step_q;
                    end else begin
                        col_d  = col_sum[COL_BITS-1:0];
                        addr_d = addr_q + ADDR_BITS'(stride_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            row_base_q  <= '0;
            row_step_q  <= '0;
            width_q     <= '0;
            height_q    <= '0;
            stride_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            row_base_q  <= row_base_d;
            row_step_q  <= row_step_d;
            width_q     <= width_d;
            height_q    <= height_d;
            stride_q    <= stride_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign out_valid = out_valid_q;
    assign col       = col_q;
    assign row       = row_q;
    assign addr      = addr_q;
    assign line_end  = out_valid_q & last_col;
    assign frame_end = out_valid_q & last_col & last_row;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_i_raster_counter.sv
// Bench for i_raster_counter: a frame-level beat-list model checked every cycle,
// plus literal expectations for the directed frames.
module tb_i_raster_counter;

    localparam int CB = 13;
    localparam int RB = 13;
    localparam int SB = 4;
    localparam int AB = CB + RB;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          start = 1'b0;
    logic [CB-1:0] img_width = '0;
    logic [RB-1:0] img_height = '0;
    logic [SB-1:0] stride = '0;
    logic          out_ready = 1'b0;
    logic          out_valid, line_end, frame_end, busy, done, cfg_error;
    logic [CB-1:0] col;
    logic [RB-1:0] row;
    logic [AB-1:0] addr;

    i_raster_counter dut (
        .clk(clk), .clear(clear), .start(start), .img_width(img_width),
        .img_height(img_height), .stride(stride), .out_ready(out_ready),
        .out_valid(out_valid), .col(col), .row(row), .addr(addr),
        .line_end(line_end), .frame_end(frame_end), .busy(busy),
        .done(done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r;
        int a;
        bit le;
        bit fe;
    } beat_t;

    beat_t mq[$];
    int    m_phase = 0;
    bit    m_done = 0, m_cfg = 0, m_zero = 1;
    int    n_checks = 0, n_fail = 0;
    int    done_cnt = 0, cfg_cnt = 0;
    bit    snap_valid = 0;
    int    snap_col = 0, snap_row = 0, snap_addr = 0;
    int    hs_col[$], hs_row[$], hs_addr[$];
    bit    rnd_ready = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats of one frame, straight from the row-major walk definition.
    task automatic build_frame(input int w, input int h, input int s);
        mq.delete();
        for (int r = 0; r < h; r += s)
            for (int c = 0; c < w; c += s)
                mq.push_back('{c, r, r * w + c, (c + s >= w), (c + s >= w) && (r + s >= h)});
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk);
            if (!clear && snap_valid && out_ready) begin
                hs_col.push_back(snap_col);
                hs_row.push_back(snap_row);
                hs_addr.push_back(snap_addr);
            end
            if (clear) begin
                m_phase = 0; mq.delete(); m_done = 0; m_cfg = 0; m_zero = 1;
            end else begin
                case (m_phase)
                    0: begin
                        m_done = 0; m_cfg = 0;
                        if (start) begin
                            if (img_width != 0 && img_height != 0 && stride != 0) begin
                                build_frame(int'(img_width), int'(img_height), int'(stride));
                                m_phase = 1; m_zero = 0;
                            end else begin
                                m_cfg = 1;
                            end
                        end
                    end
                    1: begin
                        m_done = 0; m_cfg = 0;
                        if (out_ready) begin
                            void'(mq.pop_front());
                            if (mq.size() == 0) begin
                                m_phase = 2; m_done = 1;
                            end
                        end
                    end
                    default: begin
                        m_done = 0; m_phase = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge clk);
            #1;
            snap_valid = out_valid;
            snap_col   = int'(col);
            snap_row   = int'(row);
            snap_addr  = int'(addr);
            chk("out_valid", out_valid, m_phase == 1);
            chk("busy", busy, m_phase == 1);
            chk("done", done, m_done);
            chk("cfg_error", cfg_error, m_cfg);
            if (m_phase == 1 && mq.size() > 0) begin
                chk("col", col, mq[0].c);
                chk("row", row, mq[0].r);
                chk("addr", addr, mq[0].a);
                chk("line_end", line_end, mq[0].le);
                chk("frame_end", frame_end, mq[0].fe);
            end else begin
                chk("line_end_idle", line_end, 0);
                chk("frame_end_idle", frame_end, 0);
            end
            if (m_zero) begin
                chk("col_rst", col, 0);
                chk("row_rst", row, 0);
                chk("addr_rst", addr, 0);
            end
            if (done) done_cnt++;
            if (cfg_error) cfg_cnt++;
        end
    endtask

    task automatic start_frame(input int w, input int h, input int s);
        @(negedge clk);
        hs_col.delete(); hs_row.delete(); hs_addr.delete();
        img_width = CB'(w); img_height = RB'(h); stride = SB'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        img_width = CB'($urandom); img_height = RB'($urandom); stride = SB'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (n < budget) begin
            @(negedge clk);
            if (done_cnt != d0) break;
            if (rnd_ready) begin
                out_ready = ($urandom_range(0, 99) < 60);
                start = ($urandom_range(0, 7) == 0);
            end
            n++;
        end
        chk("frame_completed", done_cnt - d0, 1);
        start = rnd_ready;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int exp2[6];
        int maxc, d0, c0, n;
        fork
            model_loop();
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        clear = 1'b0;
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);

        // 4x3 stride 1, always ready
        out_ready = 1'b1;
        start_frame(4, 3, 1);
        wait_done(200);
        chk("f1_beats", hs_addr.size(), 12);
        if (hs_addr.size() == 12) begin
            chk("f1_last_addr", hs_addr[11], 11);
            chk("f1_col3", hs_col[3], 3);
            chk("f1_last_row", hs_row[11], 2);
            chk("f1_row4", hs_row[4], 1);
        end

        // 5x3 stride 2
        start_frame(5, 3, 2);
        wait_done(200);
        exp2 = '{0, 2, 4, 10, 12, 14};
        chk("f2_beats", hs_addr.size(), 6);
        if (hs_addr.size() == 6)
            for (int i = 0; i < 6; i++) chk("f2_addr", hs_addr[i], exp2[i]);

        // 4x3 stride 1 with backpressure
        rnd_ready = 1;
        start_frame(4, 3, 1);
        wait_done(400);
        rnd_ready = 0;
        chk("f3_beats", hs_addr.size(), 12);
        if (hs_addr.size() == 12)
            for (int i = 0; i < 12; i++) chk("f3_addr", hs_addr[i], i);

        // rejected starts
        c0 = cfg_cnt;
        start_frame(0, 3, 1);
        repeat (2) @(negedge clk);
        start_frame(4, 3, 0);
        repeat (2) @(negedge clk);
        chk("cfg_error_pulses", cfg_cnt - c0, 2);

        // clear with start mid-frame
        d0 = done_cnt;
        start_frame(4, 3, 1);
        n = 0;
        while (hs_addr.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("clear_reached_beat5", hs_addr.size(), 5);
        clear = 1'b1; start = 1'b1;
        img_width = 4; img_height = 3; stride = 1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        chk("clear_valid", out_valid, 0);
        chk("clear_addr", addr, 0);
        repeat (20) @(negedge clk);
        chk("clear_no_done", done_cnt - d0, 0);
        start_frame(4, 3, 1);
        wait_done(200);
        chk("after_clear_beats", hs_addr.size(), 12);

        // random configurations with backpressure
        for (int k = 0; k < 12; k++) begin
            rnd_ready = ($urandom_range(0, 1) == 1);
            start_frame($urandom_range(1, 20), $urandom_range(1, 12), $urandom_range(1, 6));
            wait_done(2000);
        end
        rnd_ready = 0;

        // widest line, large stride
        start_frame(8191, 2, 15);
        wait_done(3000);
        chk("big_beats", hs_addr.size(), 547);
        maxc = 0;
        foreach (hs_col[i]) if (hs_col[i] > maxc) maxc = hs_col[i];
        chk("big_max_col", maxc, 8190);
        if (hs_addr.size() == 547) chk("big_last_addr", hs_addr[546], 8190);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
